// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: ALU control codes, ALUOp and
// funct encodings, and the FSM state type.
package alu_issue_ctrl_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_XOR = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MUL  = 7'b0000001;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_AND = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu_issue_ctrl_decode.sv
// Combinational decode of ALUOp/funct fields into the 3-bit ALU control code,
// plus multicycle, shift and illegal flags.
module alu_issue_ctrl_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic [6:0] imm_hi,
  output logic [2:0] alu_ctrl,
  output logic       is_mul,
  output logic       is_shift,
  output logic       illegal
);

  logic [2:0] ctrl_s;
  logic       illegal_s;

  // Instruction field decode; anything unlisted is illegal and falls back to ADD.
  always_comb begin
    ctrl_s    = ALU_ADD;
    illegal_s = 1'b0;
    case (alu_op)
      ALUOP_MEM: ctrl_s = ALU_ADD;
      ALUOP_R: begin
        case ({funct7, funct3})
          {F7_BASE, F3_AND}: ctrl_s = ALU_AND;
          {F7_BASE, F3_XOR}: ctrl_s = ALU_XOR;
          {F7_BASE, F3_SLL}: ctrl_s = ALU_SLL;
          {F7_BASE, F3_ADD}: ctrl_s = ALU_ADD;
          {F7_ALT,  F3_ADD}: ctrl_s = ALU_SUB;
          {F7_MUL,  F3_ADD}: ctrl_s = ALU_MUL;
          {F7_ALT,  F3_SR}:  ctrl_s = ALU_SRA;
          default:           illegal_s = 1'b1;
        endcase
      end
      ALUOP_I: begin
        // For I-type shifts the funct7 slot lives in imm[11:5].
        if (funct3 == F3_ADD) begin
          ctrl_s = ALU_ADD;
        end else if ((funct3 == F3_SR) && (imm_hi == F7_ALT)) begin
          ctrl_s = ALU_SRA;
        end else begin
          illegal_s = 1'b1;
        end
      end
      default: illegal_s = 1'b1;
    endcase
  end

  assign alu_ctrl = ctrl_s;
  assign illegal  = illegal_s;
  assign is_mul   = (ctrl_s == ALU_MUL) && !illegal_s;
  assign is_shift = ((ctrl_s == ALU_SLL) || (ctrl_s == ALU_SRA)) && !illegal_s;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Producer side of the ALU interface: decodes requests, holds registered operands
// on the combinational ALU for N cycles, then returns the captured result.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int MUL_CYCLES  = 4,
  parameter int BASE_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  ALUOp_i,
  input  logic [6:0]  funct7_i,
  input  logic [2:0]  funct3_i,
  input  logic        ALUSrc_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [31:0] imm_i,
  output logic [2:0]  ALUCtrl_o,
  output logic [31:0] data1_o,
  output logic [31:0] data2_o,
  input  logic [31:0] alu_result_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic        rsp_illegal_o
);

  localparam int MAX_CYC = (MUL_CYCLES > BASE_CYCLES) ? MUL_CYCLES : BASE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BASE_LOAD = CNT_W'(BASE_CYCLES - 1);

  state_e            state_r, state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [2:0]        ctrl_r;
  logic [31:0]       data1_r, data2_r, rsp_data_r;
  logic              rsp_valid_r, rsp_illegal_r;
  logic              start_s, capture_s, ready_s;

  logic [2:0]        dec_ctrl_s;
  logic              dec_mul_s, dec_shift_s, dec_illegal_s;
  logic [31:0]       op2_s, op2_sel_s;

  alu_issue_ctrl_decode u_decode (
    .alu_op   (ALUOp_i),
    .funct7   (funct7_i),
    .funct3   (funct3_i),
    .imm_hi   (imm_i[11:5]),
    .alu_ctrl (dec_ctrl_s),
    .is_mul   (dec_mul_s),
    .is_shift (dec_shift_s),
    .illegal  (dec_illegal_s)
  );

  assign op2_s     = ALUSrc_i ? imm_i : rs2_data_i;
  assign op2_sel_s = dec_shift_s ? {27'd0, op2_s[4:0]} : op2_s;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state, handshake and datapath-enable decode.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    capture_s    = 1'b0;
    ready_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        ready_s = 1'b1;
        if (req_valid_i) begin
          start_s = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (cnt_r == '0) begin
          capture_s    = 1'b1;
          state_next_s = ST_RESP;
        end else begin
          state_next_s = ST_EXEC;
        end
      end
      ST_RESP: begin
        ready_s = rsp_ready_i;
        if (rsp_ready_i && req_valid_i) begin
          start_s = 1'b1;
        end else if (rsp_ready_i) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_RESP;
        end
      end
      default: state_next_s = ST_IDLE;
    endcase
    if (start_s) begin
      state_next_s = dec_illegal_s ? ST_RESP : ST_EXEC;
    end else begin
      state_next_s = state_next_s;
    end
  end

  // Operand, counter and response registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_r        <= ALU_ADD;
      data1_r       <= 32'd0;
      data2_r       <= 32'd0;
      cnt_r         <= '0;
      rsp_valid_r   <= 1'b0;
      rsp_data_r    <= 32'd0;
      rsp_illegal_r <= 1'b0;
    end else begin
      rsp_valid_r <= (state_next_s == ST_RESP);
      if (start_s && dec_illegal_s) begin
        rsp_illegal_r <= 1'b1;
        rsp_data_r    <= 32'd0;
      end else if (start_s) begin
        ctrl_r  <= dec_ctrl_s;
        data1_r <= rs1_data_i;
        data2_r <= op2_sel_s;
        cnt_r   <= dec_mul_s ? MUL_LOAD : BASE_LOAD;
      end else if (capture_s) begin
        rsp_data_r    <= alu_result_i;
        rsp_illegal_r <= 1'b0;
      end else if (state_r == ST_EXEC) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end
    end
  end

  assign req_ready_o   = ready_s;
  assign ALUCtrl_o     = ctrl_r;
  assign data1_o       = data1_r;
  assign data2_o       = data2_r;
  assign rsp_valid_o   = rsp_valid_r;
  assign rsp_data_o    = rsp_data_r;
  assign rsp_illegal_o = rsp_illegal_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU on the ALU-facing ports.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  alu_op = 2'b00;
  logic [6:0]  f7 = 7'd0;
  logic [2:0]  f3 = 3'd0;
  logic        alu_src = 1'b0;
  logic [31:0] rs1 = 32'd0, rs2 = 32'd0, imm = 32'd0;
  logic [2:0]  alu_ctrl;
  logic [31:0] d1, d2, alu_res, rsp_data;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_illegal;
  logic [63:0] prod;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.MUL_CYCLES(4), .BASE_CYCLES(1)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .ALUOp_i(alu_op), .funct7_i(f7), .funct3_i(f3), .ALUSrc_i(alu_src),
    .rs1_data_i(rs1), .rs2_data_i(rs2), .imm_i(imm),
    .ALUCtrl_o(alu_ctrl), .data1_o(d1), .data2_o(d2), .alu_result_i(alu_res),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_illegal_o(rsp_illegal)
  );

  assign prod = d1 * d2;
  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_res = d1 & d2;
      3'b001:  alu_res = d1 ^ d2;
      3'b010:  alu_res = d1 << d2[4:0];
      3'b011:  alu_res = d1 + d2;
      3'b100:  alu_res = d1 - d2;
      3'b101:  alu_res = prod[31:0];
      3'b110:  alu_res = $signed(d1) >>> d2[4:0];
      default: alu_res = 32'd0;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [6:0] a7, input logic [2:0] a3,
                      input logic src, input logic [31:0] r1, input logic [31:0] r2,
                      input logic [31:0] im);
    alu_op = op; f7 = a7; f3 = a3; alu_src = src; rs1 = r1; rs2 = r2; imm = im;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    tick(); tick();
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_ctrl", {29'd0, alu_ctrl}, 32'd3);
    chk("rst_d1", d1, 32'd0);
    chk("rst_d2", d2, 32'd0);
    chk("rst_data", rsp_data, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;

    // ADD, N=1
    send(2'b10, 7'b0000000, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0);
    chk("add_ctrl", {29'd0, alu_ctrl}, 32'd3);
    chk("add_busy", {31'd0, req_ready}, 32'd0);
    chk("add_novalid", {31'd0, rsp_valid}, 32'd0);
    tick();
    chk("add_valid", {31'd0, rsp_valid}, 32'd1);
    chk("add_data", rsp_data, 32'd12);
    chk("add_ill", {31'd0, rsp_illegal}, 32'd0);
    tick();
    chk("add_idle", {31'd0, rsp_valid}, 32'd0);

    // MUL, N=4
    send(2'b10, 7'b0000001, 3'b000, 1'b0, 32'hFFFFFFFF, 32'd3, 32'd0);
    chk("mul_ctrl", {29'd0, alu_ctrl}, 32'd5);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("mul_busy", {31'd0, req_ready}, 32'd0);
      chk("mul_novalid", {31'd0, rsp_valid}, 32'd0);
      chk("mul_d1", d1, 32'hFFFFFFFF);
      chk("mul_d2", d2, 32'd3);
    end
    tick();
    chk("mul_valid", {31'd0, rsp_valid}, 32'd1);
    chk("mul_data", rsp_data, 32'hFFFFFFFD);
    chk("mul_d1_hold", d1, 32'hFFFFFFFF);
    tick();

    // SRAI: shift amount from imm[4:0]
    send(2'b11, 7'b0000000, 3'b101, 1'b1, 32'h00000400, 32'd0, 32'h00000402);
    chk("srai_ctrl", {29'd0, alu_ctrl}, 32'd6);
    chk("srai_d2", d2, 32'd2);
    tick();
    chk("srai_data", rsp_data, 32'h00000100);
    tick();

    // SLL masks rs2 to 5 bits
    send(2'b10, 7'b0000000, 3'b001, 1'b0, 32'd1, 32'h00000021, 32'd0);
    chk("sll_d2", d2, 32'd1);
    tick();
    chk("sll_data", rsp_data, 32'd2);
    tick();

    // Illegal R-type: straight to response, operands untouched
    send(2'b10, 7'b0000000, 3'b010, 1'b0, 32'hAAAA, 32'hBBBB, 32'd0);
    chk("ill_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ill_flag", {31'd0, rsp_illegal}, 32'd1);
    chk("ill_data", rsp_data, 32'd0);
    chk("ill_d1", d1, 32'd1);
    chk("ill_d2", d2, 32'd1);
    chk("ill_ctrl", {29'd0, alu_ctrl}, 32'd2);
    tick();

    // ALUOp=01 is illegal
    send(2'b01, 7'b0000000, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0);
    chk("op01_ill", {31'd0, rsp_illegal}, 32'd1);
    tick();

    // SUB, then result clears illegal flag
    send(2'b10, 7'b0100000, 3'b000, 1'b0, 32'd10, 32'd3, 32'd0);
    tick();
    chk("sub_data", rsp_data, 32'd7);
    chk("sub_ill", {31'd0, rsp_illegal}, 32'd0);
    tick();

    // Backpressure on a mem ADD (imm operand)
    send(2'b00, 7'b0000000, 3'b000, 1'b1, 32'h10, 32'hDEAD, 32'h20);
    rsp_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, 32'h30);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    // Same-cycle retire + accept of a MUL
    rsp_ready = 1'b1;
    alu_op = 2'b10; f7 = 7'b0000001; f3 = 3'b000; alu_src = 1'b0; rs1 = 32'd6; rs2 = 32'd7;
    req_valid = 1'b1;
    #1;
    chk("ra_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("ra_retired", {31'd0, rsp_valid}, 32'd0);
    chk("ra_ctrl", {29'd0, alu_ctrl}, 32'd5);
    chk("ra_d1", d1, 32'd6);
    tick();
    // Reset mid-EXEC drops the MUL
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mrst_ctrl", {29'd0, alu_ctrl}, 32'd3);
    chk("mrst_d1", d1, 32'd0);
    chk("mrst_ready", {31'd0, req_ready}, 32'd1);
    tick(); tick(); tick(); tick();
    chk("mrst_dropped", {31'd0, rsp_valid}, 32'd0);

    // XOR after reset
    send(2'b10, 7'b0000000, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0);
    tick();
    chk("xor_data", rsp_data, 32'h0FF00FF0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
